regcheck_sequencer: RTL and testbench
=====================================

// Module: regcheck_sequencer
// PURPOSE
//  Synthesizable self-check sequencer for the multicycle RV32I core.
//  - Holds the CPU in reset, releases it on start, detects the halt idiom (JAL x0,0) on the fetch bus.
//  - Then walks a programmable table of expected register values through the register-file debug read port.
//  - Reports pass/fail; replaces per-test hand-written register checks.
// PARAMETERS
//  XLEN       32            datapath / register width
//  NCHK       8             expected-value table entries (1..32)
//  HALT_WORD  32'h0000006f  instruction word treated as halt
//  HALT_HITS  2             consecutive halt fetches at same pc required (>=1)
//  TIMEOUT    4095          max RUN cycles before abort (counter width $clog2(TIMEOUT+1))
// PORTS
//  clk          in   1                 clock; all logic on rising edge
//  rst          in   1                 synchronous reset, active-low
//  start        in   1                 pulse: begin run (ignored unless IDLE or DONE)
//  cpu_hold     out  1                 1 = CPU held in reset
//  instr_valid  in   1                 fetch strobe from CPU
//  instr        in   XLEN              fetched instruction word
//  pc           in   XLEN              address of fetched instruction
//  dbg_addr     out  5                 register-file debug read address
//  dbg_data     in   XLEN              debug read data, valid 1 cycle after dbg_addr
//  cfg_we       in   1                 table write strobe (honoured in IDLE/DONE only)
//  cfg_idx      in   $clog2(NCHK)      table entry index; idx>=NCHK ignored
//  cfg_en       in   1                 entry enable
//  cfg_reg      in   5                 register number to check
//  cfg_val      in   XLEN              expected value
//  cfg_mask     in   XLEN              compare mask (used only with REGCHECK_MASK_EN)
//  busy         out  1                 high in RUN/CHK_REQ/CHK_CMP
//  done         out  1                 sticky until next start or reset
//  pass         out  1                 valid when done: no failures and no timeout
//  timeout      out  1                 valid when done: RUN aborted by TIMEOUT
//  fail_count   out  $clog2(NCHK+1)    number of failing enabled entries
//  fail_idx     out  $clog2(NCHK)      index of first failing entry (0 if none)
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, cpu_hold=1, busy=0, done=0, pass=0, timeout=0,
//    fail_count=0, fail_idx=0, dbg_addr=0; all table entries disabled.
//  - IDLE: cpu_hold=1. start -> RUN next cycle; cpu_hold drops in same edge; counters cleared.
//  - RUN: timeout counter +1 per cycle. Halt counter: +1 on instr_valid with instr==HALT_WORD
//    and pc==pc of previous halt fetch (first hit loads pc, counts 1); any other valid fetch clears it.
//    Count reaching HALT_HITS -> CHK_REQ, cpu_hold=1 same edge (core frozen for readback).
//    Counter reaching TIMEOUT -> DONE with timeout=1, pass=0, table not walked.
//    Halt and timeout on same cycle: halt wins.
//  - CHK_REQ: pointer i from 0; skip disabled entries (one per cycle); drive dbg_addr=reg[i] -> CHK_CMP.
//  - CHK_CMP: compare dbg_data vs val[i]; mismatch: fail_count+1, fail_idx=i if first.
//    i==NCHK-1 -> DONE, else i+1 -> CHK_REQ. Walk latency <= 2*NCHK cycles after halt.
//  - Check of x0 expects 0; dbg_data for x0 compared as-is (no special case).
//  - DONE: done=1, busy=0, pass=(fail_count==0)&&!timeout, cpu_hold=1. start restarts (clears results).
//  - start while busy: ignored. cfg_we while busy: ignored (table stable during a run).
//  - No enabled entries: walk completes, pass=1 unless timeout.
//  - rst mid-run: immediate return to reset state; table cleared.
// CONFIGURATION
//  REGCHECK_MASK_EN defined: per-entry mask stored; mismatch = |((dbg_data^val)&mask).
//  Undefined: cfg_mask ignored, no mask storage; mismatch = (dbg_data!=val) full width.
// TESTING
//  T1 branch program (ADDI/BEQ/BNE/BLT/BGE/BLTU/BGEU, halt at word 30); table x5=10,x7=10,x9=-5,
//     x11=5,x13=10,x15=20 -> done=1, pass=1, fail_count=0.
//  T2 same program, entry 2 expects x9=0 -> pass=0, fail_count=1, fail_idx=2.
//  T3 program without halt (loop of ADDI), TIMEOUT=200 -> done after 200 RUN cycles, timeout=1, pass=0.
//  T4 HALT_HITS=2: single HALT_WORD fetch then other instr -> stays RUN; two at same pc -> CHK_REQ.
//  T5 rst low during CHK_CMP -> next cycle IDLE, cpu_hold=1, done=0, all entries disabled; start
//     with empty table -> pass=1.
//  T6 REGCHECK_MASK_EN: expect x5=0x0000000F mask 0x0F, actual 10 -> fail; mask 0x0A -> pass.

Source files
------------

// File: rtl/regcheck_sequencer.sv
// regcheck_sequencer
//   Self-check sequencer for the multicycle RV32I core. It holds the core in
//   reset until start, releases it, watches the fetch bus for the halt idiom,
//   then walks a programmable table of expected register values through the
//   register-file debug read port and reports pass/fail.
//
//   Optional feature macro: REGCHECK_MASK_EN
//     defined   : a per-entry compare mask is stored, mismatch = |((data^val)&mask)
//     undefined : cfg_mask is ignored, mismatch = full-width inequality
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-low reset
//   start              begin a run (accepted in IDLE or DONE only)
//   cpu_hold           1 = CPU held in reset
//   instr_valid/instr/pc  fetch bus observed from the CPU
//   dbg_addr/dbg_data  register-file debug read port (data valid 1 cycle later)
//   cfg_we/idx/en/reg/val/mask  expected-value table write port (IDLE/DONE only)
//   busy, done, pass, timeout, fail_count, fail_idx  status / results
module regcheck_sequencer #(
  parameter int                XLEN      = 32,
  parameter int                NCHK      = 8,
  parameter logic [XLEN-1:0]   HALT_WORD = 32'h0000006f,
  parameter int                HALT_HITS = 2,
  parameter int                TIMEOUT   = 4095,
  localparam int               IW        = (NCHK > 1) ? $clog2(NCHK) : 1,
  localparam int               FW        = $clog2(NCHK + 1),
  localparam int               TW        = $clog2(TIMEOUT + 1),
  localparam int               HW        = $clog2(HALT_HITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            cpu_hold,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic            cfg_en,
  input  logic [4:0]      cfg_reg,
  input  logic [XLEN-1:0] cfg_val,
  input  logic [XLEN-1:0] cfg_mask,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [FW-1:0]   fail_count,
  output logic [IW-1:0]   fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHK_REQ,
    S_CHK_CMP,
    S_DONE
  } state_t;

  state_t state;

  // Expected-value table: enables are control (reset), contents are data.
  logic            tbl_en  [NCHK];
  logic [4:0]      tbl_reg [NCHK];
  logic [XLEN-1:0] tbl_val [NCHK];
`ifdef REGCHECK_MASK_EN
  logic [XLEN-1:0] tbl_mask [NCHK];
`else
  logic            unused_mask;
  assign unused_mask = ^cfg_mask;
`endif

  logic [IW-1:0]   ptr;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   hcnt;
  logic [HW-1:0]   hcnt_nxt;
  logic [XLEN-1:0] hpc;

  logic            idle_like;
  logic            cfg_ok;
  logic            halt_fetch;
  logic            halt_reached;
  logic            tmo_reached;
  logic            ptr_last;
  logic            mism;

  function automatic logic entry_mismatch(input logic [XLEN-1:0] act,
                                          input logic [XLEN-1:0] exp,
                                          input logic [XLEN-1:0] msk);
`ifdef REGCHECK_MASK_EN
    return |((act ^ exp) & msk);
`else
    return (act != exp) || (msk != msk);
`endif
  endfunction

  assign idle_like    = (state == S_IDLE) || (state == S_DONE);
  assign cfg_ok       = cfg_we && idle_like &&
                        ({1'b0, cfg_idx} < (IW + 1)'(NCHK));
  assign halt_fetch   = instr_valid && (instr == HALT_WORD);
  assign halt_reached = (hcnt_nxt == HW'(HALT_HITS));
  assign tmo_reached  = (tcnt == TW'(TIMEOUT - 1));
  assign ptr_last     = (ptr == IW'(NCHK - 1));

  // Halt-run counter: consecutive halt fetches at one pc; any other valid
  // fetch (or a halt at a different pc) restarts the count.
  always_comb begin
    hcnt_nxt = hcnt;
    if (instr_valid) begin
      if (instr == HALT_WORD) begin
        if ((hcnt != '0) && (pc == hpc))
          hcnt_nxt = hcnt + HW'(1);
        else
          hcnt_nxt = HW'(1);
      end else begin
        hcnt_nxt = '0;
      end
    end
  end

  always_comb begin
`ifdef REGCHECK_MASK_EN
    mism = entry_mismatch(dbg_data, tbl_val[ptr], tbl_mask[ptr]);
`else
    mism = entry_mismatch(dbg_data, tbl_val[ptr], '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCHK; i++) tbl_en[i] <= 1'b0;
    end else if (cfg_ok) begin
      tbl_en[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_reg[cfg_idx] <= cfg_reg;
      tbl_val[cfg_idx] <= cfg_val;
`ifdef REGCHECK_MASK_EN
      tbl_mask[cfg_idx] <= cfg_mask;
`endif
    end
  end

  // pc of the latest halt fetch; only meaningful while hcnt != 0.
  always_ff @(posedge clk) begin
    if ((state == S_RUN) && halt_fetch)
      hpc <= pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_count <= '0;
      fail_idx   <= '0;
      dbg_addr   <= '0;
      ptr        <= '0;
      tcnt       <= '0;
      hcnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          cpu_hold <= 1'b1;
          if (start) begin
            state      <= S_RUN;
            cpu_hold   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_count <= '0;
            fail_idx   <= '0;
            ptr        <= '0;
            tcnt       <= '0;
            hcnt       <= '0;
          end
        end

        // Halt detection takes priority over an expiring timeout.
        S_RUN: begin
          tcnt <= tcnt + TW'(1);
          hcnt <= hcnt_nxt;
          if (halt_reached) begin
            state    <= S_CHK_REQ;
            cpu_hold <= 1'b1;
            ptr      <= '0;
          end else if (tmo_reached) begin
            state    <= S_DONE;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
            pass     <= 1'b0;
          end
        end

        // Disabled entries are skipped at one per cycle.
        S_CHK_REQ: begin
          if (tbl_en[ptr]) begin
            dbg_addr <= tbl_reg[ptr];
            state    <= S_CHK_CMP;
          end else if (ptr_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0);
          end else begin
            ptr <= ptr + IW'(1);
          end
        end

        // dbg_data now reflects the address issued in CHK_REQ.
        S_CHK_CMP: begin
          if (mism) begin
            fail_count <= fail_count + FW'(1);
            if (fail_count == '0)
              fail_idx <= ptr;
          end
          if (ptr_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0) && !mism;
          end else begin
            ptr   <= ptr + IW'(1);
            state <= S_CHK_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regcheck_sequencer.sv
// tb_regcheck_sequencer
//   Directed bench for regcheck_sequencer. A behavioural stand-in for the CPU
//   drives the fetch bus, and a small register-file array answers the debug
//   read port combinationally from dbg_addr with the values the test programs
//   would leave behind.
module tb_regcheck_sequencer;

  localparam int XLEN = 32;
  localparam int NCHK = 8;
  localparam int IW   = 3;
  localparam int FW   = 4;
  localparam logic [31:0] HALT = 32'h0000006f;
  localparam logic [31:0] ADDI = 32'h00a00293;
  localparam logic [31:0] BEQ  = 32'h00000463;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            cpu_hold;
  logic            instr_valid = 1'b0;
  logic [XLEN-1:0] instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic            cfg_en = 1'b0;
  logic [4:0]      cfg_reg = '0;
  logic [XLEN-1:0] cfg_val = '0;
  logic [XLEN-1:0] cfg_mask = '0;
  logic            busy, done, pass, timeout;
  logic [FW-1:0]   fail_count;
  logic [IW-1:0]   fail_idx;

  logic [31:0] rf [32];
  assign dbg_data = rf[dbg_addr];

  int errors = 0;
  int checks = 0;
  int n;

  regcheck_sequencer #(
    .XLEN(XLEN), .NCHK(NCHK), .HALT_WORD(HALT), .HALT_HITS(2), .TIMEOUT(200)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cpu_hold(cpu_hold),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg),
    .cfg_val(cfg_val), .cfg_mask(cfg_mask),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_count(fail_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic en, input int r,
                     input logic [31:0] val, input logic [31:0] msk);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_en   = en;
    cfg_reg  = 5'(r);
    cfg_val  = val;
    cfg_mask = msk;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] w, input logic [31:0] a);
    instr_valid = 1'b1;
    instr       = w;
    pc          = a;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic halt2(input logic [31:0] a);
    fetch(HALT, a);
    fetch(HALT, a);
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (!done && cnt < max) begin
      tick();
      cnt++;
    end
    if (!done) chk("wait_done_expired", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[5] = 32'd10; rf[7] = 32'd10; rf[9] = 32'hFFFF_FFFB;
    rf[11] = 32'd5; rf[13] = 32'd10; rf[15] = 32'd20;

    // Reset state
    tick(); tick();
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_fail_count", 32'(fail_count), 0);
    chk("rst_fail_idx", 32'(fail_idx), 0);
    chk("rst_dbg_addr", 32'(dbg_addr), 0);
    rst = 1'b1;
    tick();

    // T1: branch program, all expectations correct
    cfg(0, 1'b1, 5,  32'd10,        '1);
    cfg(1, 1'b1, 7,  32'd10,        '1);
    cfg(2, 1'b1, 9,  32'hFFFF_FFFB, '1);
    cfg(3, 1'b1, 11, 32'd5,         '1);
    cfg(4, 1'b1, 13, 32'd10,        '1);
    cfg(5, 1'b1, 15, 32'd20,        '1);
    pulse_start();
    chk("t1_run_hold", 32'(cpu_hold), 0);
    chk("t1_run_busy", 32'(busy), 1);
    for (int k = 0; k < 30; k++) fetch((k % 2 == 0) ? ADDI : BEQ, 32'(k * 4));
    fetch(HALT, 32'h78);
    chk("t1_one_halt_hold", 32'(cpu_hold), 0);
    fetch(HALT, 32'h78);
    chk("t1_halt_hold", 32'(cpu_hold), 1);
    chk("t1_halt_busy", 32'(busy), 1);
    wait_done(100, n);
    chk("t1_walk_latency_ok", 32'(n <= 2 * NCHK), 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail_count", 32'(fail_count), 0);
    chk("t1_timeout", 32'(timeout), 0);
    chk("t1_busy", 32'(busy), 0);

    // T2 + T4: entry 2 expects 0; halt-hit sequencing; writes/start while busy
    cfg(2, 1'b1, 9, 32'd0, '1);
    pulse_start();
    chk("t2_done_cleared", 32'(done), 0);
    cfg(2, 1'b1, 9, 32'hFFFF_FFFB, '1);
    fetch(HALT, 32'h10);
    fetch(ADDI, 32'h14);
    fetch(HALT, 32'h10);
    chk("t4_interrupted_hold", 32'(cpu_hold), 0);
    fetch(HALT, 32'h20);
    chk("t4_newpc_hold", 32'(cpu_hold), 0);
    fetch(HALT, 32'h20);
    chk("t4_two_hits_hold", 32'(cpu_hold), 1);
    pulse_start();
    chk("t2_start_busy_hold", 32'(cpu_hold), 1);
    chk("t2_start_busy_busy", 32'(busy), 1);
    wait_done(100, n);
    chk("t2_pass", 32'(pass), 0);
    chk("t2_fail_count", 32'(fail_count), 1);
    chk("t2_fail_idx", 32'(fail_idx), 2);

    // T3: no halt, timeout after 200 RUN cycles
    pulse_start();
    n = 0;
    while (!done && n < 400) begin
      fetch(ADDI, 32'(n * 4));
      n++;
    end
    chk("t3_cycles", 32'(n), 200);
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_fail_count", 32'(fail_count), 0);
    chk("t3_hold", 32'(cpu_hold), 1);

    // T5: reset during CHK_CMP, then empty-table run
    pulse_start();
    halt2(32'h40);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_hold", 32'(cpu_hold), 1);
    chk("t5_done", 32'(done), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_fail_count", 32'(fail_count), 0);
    chk("t5_dbg_addr", 32'(dbg_addr), 0);
    rst = 1'b1;
    tick();
    pulse_start();
    halt2(32'h40);
    wait_done(100, n);
    chk("t5_empty_walk_cycles", 32'(n), NCHK);
    chk("t5_empty_pass", 32'(pass), 1);
    chk("t5_empty_fail_count", 32'(fail_count), 0);

    // T6: masked compare (full compare in the default build)
    cfg(0, 1'b1, 5, 32'h0000_000F, 32'h0000_000F);
    cfg(3, 1'b1, 7, 32'd99,        32'hFFFF_FFFF);
    pulse_start();
    halt2(32'h80);
    wait_done(100, n);
    chk("t6a_pass", 32'(pass), 0);
    chk("t6a_fail_count", 32'(fail_count), 2);
    chk("t6a_fail_idx", 32'(fail_idx), 0);
    cfg(0, 1'b1, 5, 32'h0000_000F, 32'h0000_000A);
    pulse_start();
    halt2(32'h80);
    wait_done(100, n);
`ifdef REGCHECK_MASK_EN
    chk("t6b_fail_count", 32'(fail_count), 1);
    chk("t6b_fail_idx", 32'(fail_idx), 3);
`else
    chk("t6b_fail_count", 32'(fail_count), 2);
    chk("t6b_fail_idx", 32'(fail_idx), 0);
`endif
    chk("t6b_pass", 32'(pass), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
